// File: rtl/if_fetch_if.sv
// if_fetch_if: request/response bus between the fetch stage, the memory
// controller instruction port and decode.
//   master : fetch stage  (drives request and id_* head, receives response and id_ready)
//   slave  : controller + decode side (mirror image)
// Op/len encoding: MEM_NOP = 2'd0, MEM_LOAD = 2'd1, MEM_WORD = 2'd2.
interface if_fetch_if;
  logic [1:0]  mem_if_op;
  logic [1:0]  mem_if_len;
  logic [31:0] mem_if_addr;
  logic        mem_if_rdy;
  logic [31:0] mem_if_data;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_ready;

  modport master (
    output mem_if_op, mem_if_len, mem_if_addr,
    input  mem_if_rdy, mem_if_data,
    output id_valid, id_inst, id_pc,
    input  id_ready
  );

  modport slave (
    input  mem_if_op, mem_if_len, mem_if_addr,
    output mem_if_rdy, mem_if_data,
    input  id_valid, id_inst, id_pc,
    output id_ready
  );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage. Holds the PC, keeps one word fetch
// outstanding at a time and buffers {pc, inst} pairs in a FIFO drained by
// decode over a valid/ready handshake. A taken jump flushes and redirects.
//
// Parameters:
//   QUEUE_DEPTH : FIFO entries, power of two, >= 2
//   RESET_PC    : PC loaded at reset
// Ports:
//   clk_in      : clock, rising edge
//   rst_in      : asynchronous active-high reset
//   rdy_in      : global ready, low freezes all state
//   jmp_in      : taken jump / redirect (highest priority)
//   jmp_addr_in : redirect target
//   bus         : if_fetch_if.master (mem_if_* request/response, id_* head)
// Build option:
//   IF_BYPASS_EN : when defined, a response arriving with an empty FIFO is
//                  presented on id_* in the same cycle (zero latency).
module if_fetch #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        jmp_in,
  input  logic [31:0] jmp_addr_in,
  if_fetch_if.master  bus
);

  localparam logic [1:0] MEM_NOP  = 2'd0;
  localparam logic [1:0] MEM_LOAD = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t           state;
  logic [31:0]      pc;
  logic [1:0]       op_q;
  logic [31:0]      addr_q;
  logic [31:0]      inst_mem [QUEUE_DEPTH];
  logic [31:0]      pc_mem   [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             head_valid;
  logic             resp_ok;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] cnt_next;
  logic             id_valid_c;
  logic [31:0]      id_inst_c;
  logic [31:0]      id_pc_c;

  // Handshake decode and head presentation
  always_comb begin
    head_valid = (count != '0);
    resp_ok    = rdy_in && !jmp_in && (state == ST_WAIT) && bus.mem_if_rdy;
    pop        = rdy_in && !jmp_in && head_valid && bus.id_ready;
`ifdef IF_BYPASS_EN
    // Empty FIFO: forward the response straight to decode; if decode takes
    // it now it never enters the FIFO.
    id_valid_c = head_valid || resp_ok;
    id_inst_c  = head_valid ? inst_mem[rd_ptr] : (resp_ok ? bus.mem_if_data : inst_mem[rd_ptr]);
    id_pc_c    = head_valid ? pc_mem[rd_ptr]   : (resp_ok ? pc              : pc_mem[rd_ptr]);
    push       = resp_ok && !(!head_valid && bus.id_ready);
`else
    id_valid_c = head_valid;
    id_inst_c  = inst_mem[rd_ptr];
    id_pc_c    = pc_mem[rd_ptr];
    push       = resp_ok;
`endif
    cnt_next = count + CNT_W'(push) - CNT_W'(pop);
  end

  assign bus.mem_if_op   = op_q;
  assign bus.mem_if_len  = MEM_WORD;
  assign bus.mem_if_addr = addr_q;
  assign bus.id_valid    = id_valid_c;
  assign bus.id_inst     = id_inst_c;
  assign bus.id_pc       = id_pc_c;

  // Fetch FSM, PC and FIFO state
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state  <= ST_IDLE;
      pc     <= RESET_PC;
      op_q   <= MEM_NOP;
      addr_q <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (jmp_in) begin
        // Flush and redirect; any response this cycle is dropped.
        state  <= ST_IDLE;
        pc     <= jmp_addr_in;
        op_q   <= MEM_NOP;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          inst_mem[wr_ptr] <= bus.mem_if_data;
          pc_mem[wr_ptr]   <= pc;
          wr_ptr           <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count <= cnt_next;

        case (state)
          ST_IDLE: begin
            if (count < DEPTH_C) begin
              state  <= ST_WAIT;
              op_q   <= MEM_LOAD;
              addr_q <= pc;
            end
          end
          ST_WAIT: begin
            if (resp_ok) begin
              pc <= pc + 32'd4;
              // Chain the next request only if a slot remains after this cycle.
              if (cnt_next < DEPTH_C) begin
                addr_q <= pc + 32'd4;
              end else begin
                state <= ST_IDLE;
                op_q  <= MEM_NOP;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed bench for if_fetch. u0 uses RESET_PC = 0, u1 uses
// RESET_PC = 32'hFFFF_FFF8 to exercise PC wrap. Works with and without
// IF_BYPASS_EN; id_* checks move to the response cycle when it is defined.
module tb_if_fetch;

  localparam logic [1:0] MEM_NOP  = 2'd0;
  localparam logic [1:0] MEM_LOAD = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        jmp_in;
  logic [31:0] jmp_addr_in;
  logic        jmp1;
  logic [31:0] jmp_addr1;

  int total = 0;
  int bad   = 0;

  if_fetch_if bus0 ();
  if_fetch_if bus1 ();

  if_fetch #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) u0 (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .jmp_in      (jmp_in),
    .jmp_addr_in (jmp_addr_in),
    .bus         (bus0)
  );

  if_fetch #(.QUEUE_DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u1 (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .jmp_in      (jmp1),
    .jmp_addr_in (jmp_addr1),
    .bus         (bus1)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Wait lat cycles, then pulse one response on bus0 and check the head.
  task automatic respond(input logic [31:0] data, input int lat,
                         input logic [31:0] exp_pc, input bit chk_id);
    repeat (lat) tick();
    bus0.mem_if_rdy  = 1'b1;
    bus0.mem_if_data = data;
    #1;
`ifdef IF_BYPASS_EN
    if (chk_id) begin
      check("byp_valid", 32'(bus0.id_valid), 32'd1);
      check("byp_inst",  bus0.id_inst, data);
      check("byp_pc",    bus0.id_pc,   exp_pc);
    end
`endif
    @(posedge clk_in);
    #1;
    bus0.mem_if_rdy  = 1'b0;
    bus0.mem_if_data = 32'h0;
`ifndef IF_BYPASS_EN
    if (chk_id) begin
      check("head_valid", 32'(bus0.id_valid), 32'd1);
      check("head_inst",  bus0.id_inst, data);
      check("head_pc",    bus0.id_pc,   exp_pc);
    end
`endif
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; jmp_in = 1'b0; jmp_addr_in = 32'h0;
    jmp1 = 1'b0; jmp_addr1 = 32'h0;
    bus0.mem_if_rdy = 1'b0; bus0.mem_if_data = 32'h0; bus0.id_ready = 1'b1;
    bus1.mem_if_rdy = 1'b0; bus1.mem_if_data = 32'h0; bus1.id_ready = 1'b1;

    // Reset values
    #2;
    check("rst_op",    32'(bus0.mem_if_op),   32'(MEM_NOP));
    check("rst_len",   32'(bus0.mem_if_len),  32'(MEM_WORD));
    check("rst_addr",  bus0.mem_if_addr,      32'h0);
    check("rst_valid", 32'(bus0.id_valid),    32'd0);
    check("rst_inst",  bus0.id_inst,          32'h0);
    check("rst_pc",    bus0.id_pc,            32'h0);
    check("rst_addr1", bus1.mem_if_addr,      32'hFFFF_FFF8);
    tick(); tick();
    rst_in = 1'b0;
    tick();
    check("first_op",    32'(bus0.mem_if_op), 32'(MEM_LOAD));
    check("first_addr",  bus0.mem_if_addr,    32'h0);
    check("first_addr1", bus1.mem_if_addr,    32'hFFFF_FFF8);

    // PC wrap on u1
    bus1.mem_if_rdy = 1'b1; bus1.mem_if_data = 32'h13;
    tick();
    bus1.mem_if_rdy = 1'b0;
    check("wrap_addr_fffc", bus1.mem_if_addr, 32'hFFFF_FFFC);
    bus1.mem_if_rdy = 1'b1;
    tick();
    bus1.mem_if_rdy = 1'b0;
    check("wrap_addr_0", bus1.mem_if_addr, 32'h0);

    // Streaming with decode always ready
    respond(32'h13, 3, 32'h0, 1'b1);
    check("seq_addr4", bus0.mem_if_addr, 32'h4);
    check("seq_op",    32'(bus0.mem_if_op), 32'(MEM_LOAD));
    respond(32'h13, 3, 32'h4, 1'b1);
    check("seq_addr8", bus0.mem_if_addr, 32'h8);
    respond(32'h13, 3, 32'h8, 1'b1);
    check("seq_addr12", bus0.mem_if_addr, 32'hC);
    tick();

    // Decode stalled: fill to depth, then one pop allows one request
    bus0.id_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      respond(32'h100 + 32'(k), 1, 32'hC, k == 0);
      if (k < 3) begin
        check("fill_addr", bus0.mem_if_addr, 32'h10 + 32'(4 * k));
        check("fill_op",   32'(bus0.mem_if_op), 32'(MEM_LOAD));
      end else begin
        check("full_op", 32'(bus0.mem_if_op), 32'(MEM_NOP));
      end
    end
    tick(); tick();
    check("full_hold_op", 32'(bus0.mem_if_op), 32'(MEM_NOP));
    check("full_head_pc", bus0.id_pc, 32'hC);
    bus0.id_ready = 1'b1;
    tick();
    bus0.id_ready = 1'b0;
    check("pop1_head_pc", bus0.id_pc, 32'h10);
    check("pop1_op",      32'(bus0.mem_if_op), 32'(MEM_NOP));
    tick();
    check("refetch_op",   32'(bus0.mem_if_op), 32'(MEM_LOAD));
    check("refetch_addr", bus0.mem_if_addr, 32'h1C);
    respond(32'h200, 1, 32'h0, 1'b0);
    check("refull_op", 32'(bus0.mem_if_op), 32'(MEM_NOP));
    bus0.id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", bus0.id_pc, 32'h10 + 32'(4 * i));
      tick();
    end
    check("drain_valid", 32'(bus0.id_valid), 32'd0);
    check("drain_addr",  bus0.mem_if_addr, 32'h20);

    // Jump coinciding with a response: flush and redirect
    bus0.id_ready = 1'b0;
    respond(32'h77, 1, 32'h20, 1'b1);
    check("prejmp_valid", 32'(bus0.id_valid), 32'd1);
    jmp_in = 1'b1; jmp_addr_in = 32'h100;
    bus0.mem_if_rdy = 1'b1; bus0.mem_if_data = 32'hBAD;
    tick();
    jmp_in = 1'b0; bus0.mem_if_rdy = 1'b0;
    check("jmp_valid", 32'(bus0.id_valid), 32'd0);
    check("jmp_op",    32'(bus0.mem_if_op), 32'(MEM_NOP));
    tick();
    check("jmp_load_op",   32'(bus0.mem_if_op), 32'(MEM_LOAD));
    check("jmp_load_addr", bus0.mem_if_addr, 32'h100);

    // Global stall: responses and a jump ignored while rdy_in is low
    bus0.id_ready = 1'b1;
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus0.mem_if_rdy = 1'b1; bus0.mem_if_data = 32'hEE;
      jmp_in = (i == 2); jmp_addr_in = 32'h500;
      tick();
    end
    bus0.mem_if_rdy = 1'b0; jmp_in = 1'b0;
    check("frz_valid", 32'(bus0.id_valid), 32'd0);
    check("frz_op",    32'(bus0.mem_if_op), 32'(MEM_LOAD));
    check("frz_addr",  bus0.mem_if_addr, 32'h100);
    rdy_in = 1'b1;
    respond(32'h33, 1, 32'h100, 1'b1);
    check("resume_addr", bus0.mem_if_addr, 32'h104);
    tick();

    // Response into an empty FIFO with decode ready
    respond(32'hDEAD_BEEF, 1, 32'h104, 1'b1);
`ifdef IF_BYPASS_EN
    check("byp_consumed", 32'(bus0.id_valid), 32'd0);
`endif
    check("beef_addr", bus0.mem_if_addr, 32'h108);
    tick();

    // Jump with a response and an empty FIFO: nothing reaches decode
    jmp_in = 1'b1; jmp_addr_in = 32'h200;
    bus0.mem_if_rdy = 1'b1; bus0.mem_if_data = 32'h55;
    #1;
    check("jmp_empty_now", 32'(bus0.id_valid), 32'd0);
    @(posedge clk_in);
    #1;
    jmp_in = 1'b0; bus0.mem_if_rdy = 1'b0;
    check("jmp_empty_next", 32'(bus0.id_valid), 32'd0);
    tick();
    check("jmp2_addr", bus0.mem_if_addr, 32'h200);

    // Asynchronous reset mid-request with a buffered entry
    bus0.id_ready = 1'b0;
    respond(32'h99, 1, 32'h200, 1'b1);
    #3;
    rst_in = 1'b1;
    #1;
    check("arst_op",    32'(bus0.mem_if_op), 32'(MEM_NOP));
    check("arst_addr",  bus0.mem_if_addr, 32'h0);
    check("arst_valid", 32'(bus0.id_valid), 32'd0);
    check("arst_inst",  bus0.id_inst, 32'h0);
    check("arst_pc",    bus0.id_pc, 32'h0);
    #2;
    rst_in = 1'b0;
    tick();
    check("arst_load_op",   32'(bus0.mem_if_op), 32'(MEM_LOAD));
    check("arst_load_addr", bus0.mem_if_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
